// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg: shared shift-op encodings, RV32 decode constants, bundle   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam int BUNDLE_XLEN = 32;
  localparam int BUNDLE_SHW  = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10
  } shift_op_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef struct packed {
    logic [BUNDLE_XLEN-1:0] data;
    logic [BUNDLE_SHW-1:0]  shamt;
    shift_op_e              op;
    logic                   illegal;
  } shift_bundle_t;

  localparam shift_bundle_t BUNDLE_ZERO = '{data: '0, shamt: '0, op: OP_SLL, illegal: 1'b0};

endpackage
`default_nettype wire

// File: rtl/shift_issue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_issue_stage_if: decode-side and shifter-side handshake bundle  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface shift_issue_stage_if #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [SHW-1:0]  out_shamt;
  logic [1:0]      out_op;
  logic            out_illegal;

  // master: the environment around the stage (decode upstream, EX downstream)
  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, flush, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_op, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, flush, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_op, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/shift_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_decode: RV32 shift instruction -> shifter operand bundle       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   rs1_val,
  input  logic [31:0]   rs2_val,
  output shift_bundle_t bundle
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_reg;
  logic       is_imm;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign is_reg      = (opcode == OP);
  assign is_imm      = (opcode == OP_IMM);
  assign unused_bits = ^{instr[19:15], instr[11:7], rs2_val[31:5]};

  // Checking the full funct7 also rejects OP-IMM encodings with instr[25] set.
  always_comb begin
    bundle         = BUNDLE_ZERO;
    bundle.data    = rs1_val;
    bundle.illegal = 1'b1;
    if (is_reg || is_imm) begin
      if (funct3 == F3_SLL && funct7 == F7_BASE) begin
        bundle.op      = OP_SLL;
        bundle.illegal = 1'b0;
      end else if (funct3 == F3_SRX && funct7 == F7_BASE) begin
        bundle.op      = OP_SRL;
        bundle.illegal = 1'b0;
      end else if (funct3 == F3_SRX && funct7 == F7_SRA) begin
        bundle.op      = OP_SRA;
        bundle.illegal = 1'b0;
      end
    end
    if (!bundle.illegal) begin
      bundle.shamt = is_reg ? rs2_val[4:0] : instr[24:20];
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_issue_stage: decode + main/skid buffered issue to the shifter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  shift_issue_stage_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          in_ready_q;
  logic          accept;
  logic          drain;
  logic          holding;
  logic          load_main_dec;
  logic          load_main_skid;
  logic          load_skid;
  shift_bundle_t dec;
  shift_bundle_t main_q;
  shift_bundle_t skid_q;

  shift_decode u_decode (
    .instr   (bus.in_instr),
    .rs1_val (bus.in_rs1_val),
    .rs2_val (bus.in_rs2_val),
    .bundle  (dec)
  );

  assign accept = bus.in_valid && in_ready_q && !bus.flush;
  assign drain  = holding && bus.out_ready;

  // in_ready is a flop tracking "skid will be empty", so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_nxt = ST_TWO;
          else if (!accept && drain) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    holding        = (state != ST_EMPTY);
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!bus.flush) begin
      case (state)
        ST_EMPTY: load_main_dec = accept;
        ST_ONE: begin
          load_main_dec = accept && drain;
          load_skid     = accept && !drain;
        end
        ST_TWO:   load_main_skid = drain;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= BUNDLE_ZERO;
      skid_q <= BUNDLE_ZERO;
    end else begin
      if (load_main_dec) begin
        main_q <= dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = holding;
  assign bus.out_data    = main_q.data[XLEN-1:0];
  assign bus.out_shamt   = main_q.shamt[SHW-1:0];
  assign bus.out_op      = main_q.op;
  assign bus.out_illegal = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_issue_stage: directed + streaming checks of the issue stage |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_shift_issue_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  shift_issue_stage_if #(.XLEN(32), .SHW(5)) bus ();

  shift_issue_stage #(.XLEN(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] out_vec();
    return {bus.out_data, bus.out_shamt, bus.out_op, bus.out_illegal};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2f,
                                     input logic [2:0] f3, input logic [6:0] opc);
    return {f7, rs2f, 5'd1, f3, 5'd1, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_rs1_val = rs1;
    bus.in_rs2_val = rs2;
  endtask

  logic [31:0] ia, ib, ic, instr;
  logic [31:0] rs1v, rs2v;
  logic [4:0]  fld, exp_sh;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [1:0]  exp_op;
  int          kind;

  initial begin
    ia = 32'h00209033;                          // SLL reg
    ib = mk(7'h00, 5'd7, 3'b101, 7'b0010011);   // SRLI 7
    ic = mk(7'h20, 5'd2, 3'b101, 7'b0110011);   // SRA reg

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs1_val = '0; bus.in_rs2_val = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("in_ready_during_rst", bus.in_ready, 1);
    step(); step();
    rst = 1'b0;
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_outputs", out_vec(), 40'h0);

    // single SLL reg, one-cycle latency, then drains
    offer(ia, 32'h1, 32'h24);
    step();
    bus.in_valid = 1'b0;
    check("sll_valid", bus.out_valid, 1);
    check("sll_bundle", out_vec(), {32'h1, 5'd4, 2'b00, 1'b0});
    step();
    check("sll_drained", bus.out_valid, 0);

    offer(32'h41F0D093, 32'h80000000, 32'h0);
    step();
    check("srai_bundle", out_vec(), {32'h80000000, 5'd31, 2'b10, 1'b0});
    offer(32'h43F0D093, 32'h80000000, 32'h0);
    step();
    check("srai_bit25_illegal", out_vec(), {32'h80000000, 5'd0, 2'b00, 1'b1});
    offer(mk(7'h01, 5'd2, 3'b001, 7'b0110011), 32'h55, 32'h3);
    step();
    check("op_f7_illegal", out_vec(), {32'h55, 5'd0, 2'b00, 1'b1});
    offer(32'h00000013, 32'h77, 32'h0);
    step();
    check("addi_illegal", out_vec(), {32'h77, 5'd0, 2'b00, 1'b1});
    offer(ib, 32'hB0000000, 32'h0);
    step();
    check("srli_bundle", out_vec(), {32'hB0000000, 5'd7, 2'b01, 1'b0});
    bus.in_valid = 1'b0;
    step();

    // backpressure: A,B fill main+skid, C waits until the skid frees
    bus.out_ready = 1'b0;
    offer(ia, 32'hA, 32'h3);
    step();
    check("bp_one_ready", bus.in_ready, 1);
    check("bp_one_out", out_vec(), {32'hA, 5'd3, 2'b00, 1'b0});
    offer(ib, 32'hB0000000, 32'h0);
    step();
    check("bp_two_ready", bus.in_ready, 0);
    check("bp_two_hold_a", out_vec(), {32'hA, 5'd3, 2'b00, 1'b0});
    offer(ic, 32'hC, 32'h11);
    step();
    check("bp_stall_ready", bus.in_ready, 0);
    check("bp_stall_valid", bus.out_valid, 1);
    check("bp_stall_hold_a", out_vec(), {32'hA, 5'd3, 2'b00, 1'b0});
    bus.out_ready = 1'b1;
    step();
    check("bp_rel_b", out_vec(), {32'hB0000000, 5'd7, 2'b01, 1'b0});
    check("bp_rel_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_rel_c_valid", bus.out_valid, 1);
    check("bp_rel_c", out_vec(), {32'hC, 5'd17, 2'b10, 1'b0});
    step();
    check("bp_empty", bus.out_valid, 0);

    // flush while holding two entries, with a new entry offered
    bus.out_ready = 1'b0;
    offer(ia, 32'h1, 32'h1);
    step();
    offer(ib, 32'h2, 32'h0);
    step();
    check("fl_two_ready", bus.in_ready, 0);
    offer(ic, 32'hD, 32'h5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_valid", bus.out_valid, 0);
    check("fl_ready", bus.in_ready, 1);
    offer(ic, 32'hD, 32'h5);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("fl_dropped", bus.out_valid, 0);

    // asynchronous reset mid-cycle while one entry is held
    bus.out_ready = 1'b0;
    offer(ia, 32'h9, 32'h2);
    step();
    bus.in_valid = 1'b0;
    check("ar_one_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_low", bus.out_valid, 0);
    check("ar_outputs", out_vec(), 40'h0);
    check("ar_ready", bus.in_ready, 1);
    step();
    check("ar_ready_held", bus.in_ready, 1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("ar_after_valid", bus.out_valid, 0);

    // continuous stream of random legal shifts
    for (int i = 0; i < 100; i++) begin
      kind = int'($urandom_range(0, 5));
      fld  = 5'($urandom);
      rs1v = $urandom;
      rs2v = $urandom;
      f3   = (kind % 3 == 0) ? 3'b001 : 3'b101;
      f7   = (kind % 3 == 2) ? 7'h20 : 7'h00;
      exp_op = 2'(kind % 3);
      instr  = mk(f7, fld, f3, (kind < 3) ? 7'b0110011 : 7'b0010011);
      exp_sh = (kind < 3) ? rs2v[4:0] : fld;
      offer(instr, rs1v, rs2v);
      step();
      check("st_valid", bus.out_valid, 1);
      check("st_bundle", out_vec(), {rs1v, exp_sh, exp_op, 1'b0});
    end
    bus.in_valid = 1'b0;
    step();
    check("st_end_empty", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
- REQ-001: Parameter XLEN, default 32, operand data width; only 32 is supported.
- REQ-002: Parameter SHW, default 5, shift-amount width; equals log2(XLEN).
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  upstream (decode) offers an instruction.
- REQ-006: in_ready  output  1  stage can accept this cycle.
- REQ-007: in_instr  input  32  raw RV32 instruction word.
- REQ-008: in_rs1_val  input  XLEN  value to be shifted.
- REQ-009: in_rs2_val  input  XLEN  register shift source; bits [4:0] used.
- REQ-010: flush  input  1  synchronous kill of all held entries.
- REQ-011: out_valid  output  1  shifter operands valid.
- REQ-012: out_ready  input  1  downstream shifter/EX accepts.
- REQ-013: out_data  output  XLEN  operand to shifter "in".
- REQ-014: out_shamt  output  SHW  shift amount to shifter "shamt".
- REQ-015: out_op  output  2  00 SLL, 01 SRL, 10 SRA.
- REQ-016: out_illegal  output  1  entry is not a legal RV32 shift.

Function
- REQ-017: Decode SHALL be: opcode 0110011 -> shamt = in_rs2_val[4:0]; opcode 0010011 -> shamt = in_instr[24:20].
- REQ-018: funct3 001 with funct7 0000000 SHALL give SLL; funct3 101 with funct7 0000000 SRL; funct3 101 with funct7 0100000 SRA.
- REQ-019: Any other opcode/funct combination, or OP-IMM with in_instr[25]=1, SHALL set out_illegal=1, out_op=00, out_shamt=0, out_data unchanged operand.
- REQ-020: Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
- REQ-021: Latency SHALL be 1 cycle: an entry accepted at edge N is presented on out_* after edge N.
- REQ-022: Throughput SHALL be one entry per cycle while out_ready stays high.
- REQ-023: Storage SHALL be a main register plus one skid register; in_ready SHALL equal NOT skid_full, driven from a flop (no combinational path from out_ready).
- REQ-024: States: EMPTY (no entry), ONE (main valid), TWO (main and skid valid).
- REQ-025: EMPTY->ONE on accept; ONE->ONE on accept with drain; ONE->EMPTY on drain without accept; ONE->TWO on accept without drain; TWO->ONE on drain (skid moves to main, no accept).
- REQ-026: While out_valid && !out_ready, all out_* SHALL hold stable.
- REQ-027: Order SHALL be preserved; no entry duplicated or lost except by flush.
- REQ-028: flush SHALL take priority: next state EMPTY, out_valid=0, in_ready=1; an input offered in the flush cycle is dropped.
- REQ-029: Illegal entries SHALL flow through the handshake like legal ones.

Reset
- REQ-030: On rst assertion, immediately: state EMPTY, out_valid=0, out_data=0, out_shamt=0, out_op=00, out_illegal=0, skid cleared.
- REQ-031: in_ready SHALL be 1 while rst is high and after release.
- REQ-032: rst asserted mid-stall SHALL discard both entries; no transfer completes in that cycle.

Structure
- REQ-033: Package shift_pkg SHALL hold op encodings (SLL/SRL/SRA), opcode constants OP and OP_IMM, funct3/funct7 constants, and the operand bundle struct {data, shamt, op, illegal}.
- REQ-034: Combinational sub-module shift_decode SHALL map {in_instr, in_rs1_val, in_rs2_val} to the bundle; shift_issue_stage instantiates it once ahead of the registers.

Verification
- REQ-035: SLL reg: instr 0x00209033, rs1=0x00000001, rs2=0x00000024 -> next cycle out_data=0x1, out_shamt=4, out_op=00, illegal=0.
- REQ-036: SRAI: instr 0x41F0D093, rs1=0x80000000 -> out_shamt=31, out_op=10; with instr bit25 set -> illegal=1, shamt=0.
- REQ-037: Backpressure: stream A,B,C with out_ready=0 for 3 cycles -> state TWO, in_ready=0, out holds A; release -> A,B,C in order, no loss.
- REQ-038: Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry absent from output.
- REQ-039: Assert rst asynchronously mid-cycle while ONE -> out_valid falls before next clk edge; all outputs 0, in_ready=1.
- REQ-040: Continuous in_valid=out_ready=1 for 100 random legal shifts -> one output per cycle, decode matching a reference model.
